// File: rtl/fruit_pkg.sv
// rtl/fruit_pkg.sv - shared types, constants and trajectory helpers for the fruit launcher
package fruit_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, PICK, LAUNCH} launcher_state_t;

  localparam int X_BASE   = 192;
  localparam int INC_BASE = 6;
  localparam int X_CENTRE = 320;

  // Fibonacci taps 16,14,13,11 expressed on a right-shifting register (bits 0,2,3,5)
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [9:0] x_start_of(input logic [7:0] b);
    return 10'(X_BASE) + {2'b00, b};
  endfunction

  function automatic logic [10:0] inc_of(input logic [1:0] b);
    return 11'(INC_BASE) + {9'b0, b};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Fibonacci LFSR with synchronous seed load and advance enable
module lfsr16
  import fruit_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        load,
  input  logic        en,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (load) begin
      state <= SEED;
    end else if (en) begin
      state <= {^(state & LFSR_TAPS), state[15:1]};
    end
  end

endmodule

// File: rtl/fruit_launcher.sv
// rtl/fruit_launcher.sv - fruit launch scheduler; FRUIT_LAUNCHER_DIFFICULTY_RAMP_EN enables gap ramp-down
module fruit_launcher
  import fruit_pkg::*;
#(
  parameter int          N_FRUITS   = 3,
  parameter int          LAUNCH_GAP = 60,
  parameter int          MIN_GAP    = 20,
  parameter int          GRACE      = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
  input  logic                   game_active,
  input  logic [N_FRUITS-1:0]    offstage,
  output logic [N_FRUITS-1:0]    fruit_reset,
  output logic [10*N_FRUITS-1:0] xStart,
  output logic [11*N_FRUITS-1:0] increment,
  output logic [11*N_FRUITS-1:0] xincrement,
  output logic [N_FRUITS-1:0]    negate,
  output logic [N_FRUITS-1:0]    visible,
  output logic [15:0]            launch_count
);

  localparam int GW  = $clog2(((LAUNCH_GAP > MIN_GAP) ? LAUNCH_GAP : MIN_GAP) + 1);
  localparam int GRW = $clog2(GRACE + 1);

  launcher_state_t      state;
  logic [GW-1:0]        cnt;
  logic [GW-1:0]        gap_q;
  logic [GRW-1:0]       grace [N_FRUITS];
  logic [15:0]          lfsr;
  logic [15:0]          count_next;
  logic [N_FRUITS-1:0]  pick;
  logic                 fire;
  logic [9:0]           x_new;
  logic                 unused_lfsr_bits;

  // Lowest-index idle slot as a one-hot vector; zero when every slot is in flight
  function automatic logic [N_FRUITS-1:0] pick_free(input logic [N_FRUITS-1:0] vis);
    logic [N_FRUITS-1:0] r;
    r = '0;
    for (int i = N_FRUITS - 1; i >= 0; i--) begin
      if (!vis[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (frame_clk),
    .load  (Reset),
    .en    (1'b1),
    .state (lfsr)
  );

  assign pick             = pick_free(visible);
  assign fire             = (state == PICK) && game_active && (|pick);
  assign count_next       = (launch_count == 16'hFFFF) ? launch_count : launch_count + 16'd1;
  assign x_new            = x_start_of(lfsr[7:0]);
  assign unused_lfsr_bits = ^{lfsr[15:13], lfsr[8]};

`ifdef FRUIT_LAUNCHER_DIFFICULTY_RAMP_EN
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      gap_q <= GW'(LAUNCH_GAP);
    end else if (fire && (count_next[2:0] == 3'd0) && (launch_count != 16'hFFFF)) begin
      gap_q <= (gap_q >= GW'(MIN_GAP + 4)) ? gap_q - GW'(4) : GW'(MIN_GAP);
    end
  end
`else
  assign gap_q = GW'(LAUNCH_GAP);
`endif

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state        <= IDLE;
      cnt          <= '0;
      fruit_reset  <= '0;
      xStart       <= '0;
      increment    <= '0;
      xincrement   <= '0;
      negate       <= '0;
      visible      <= '0;
      launch_count <= '0;
      for (int i = 0; i < N_FRUITS; i++) grace[i] <= '0;
    end else begin
      fruit_reset <= '0;
      for (int i = 0; i < N_FRUITS; i++) begin
        if (grace[i] != '0) grace[i] <= grace[i] - GRW'(1);
        if (offstage[i] && (grace[i] == '0)) visible[i] <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (game_active) begin
            state <= WAIT;
            cnt   <= gap_q;
          end
        end
        WAIT: begin
          if (!game_active) begin
            state <= IDLE;
          end else if (cnt <= GW'(1)) begin
            cnt   <= '0;
            state <= PICK;
          end else begin
            cnt <= cnt - GW'(1);
          end
        end
        PICK: begin
          if (!game_active) begin
            state <= IDLE;
          end else if (fire) begin
            state        <= LAUNCH;
            fruit_reset  <= pick;
            launch_count <= count_next;
            // Launch assignments follow retirement so a same-frame launch keeps the slot visible
            for (int i = 0; i < N_FRUITS; i++) begin
              if (pick[i]) begin
                visible[i]            <= 1'b1;
                grace[i]              <= GRW'(GRACE);
                xStart[i*10 +: 10]    <= x_new;
                increment[i*11 +: 11] <= inc_of(lfsr[10:9]);
                xincrement[i*11 +: 11] <= {9'b0, lfsr[12:11]};
                negate[i]             <= (x_new >= 10'(X_CENTRE));
              end
            end
          end else begin
            state <= WAIT;
            cnt   <= gap_q;
          end
        end
        LAUNCH: begin
          state <= game_active ? WAIT : IDLE;
          cnt   <= gap_q;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fruit_launcher.md
Name: fruit_launcher

Overview:
- Initiator side of the fruit motion interface: decides when each fruit object is thrown and with what trajectory.
- Drives each fruit's reset pulse, start X, vertical increment, horizontal increment and negate inputs.
- Watches each fruit's offstage flag to retire the slot and recycle it.
- Sits between game control and the N fruit instances; exports per-slot visibility to the colour mapper.

Parameters:
- N_FRUITS, 3, number of fruit slots driven
- LAUNCH_GAP, 60, frames between launch attempts
- MIN_GAP, 20, floor for the gap when the ramp feature is compiled in
- GRACE, 4, frames after a launch during which offstage is ignored for that slot
- LFSR_SEED, 16'hACE1, LFSR value loaded on reset

Ports:
- frame_clk  in  1  frame clock, only clock
- Reset  in  1  synchronous, active-high reset
- game_active  in  1  high = launching enabled
- offstage  in  N_FRUITS  per-slot offstage flag from fruit instances
- fruit_reset  out  N_FRUITS  one-frame launch pulse per slot
- xStart  out  10*N_FRUITS  packed start X per slot
- increment  out  11*N_FRUITS  packed vertical speed per slot
- xincrement  out  11*N_FRUITS  packed horizontal speed per slot
- negate  out  N_FRUITS  per-slot leftward flag
- visible  out  N_FRUITS  slot in flight; gates drawing
- launch_count  out  16  total launches since reset, saturating

Behaviour:
- Clocking and reset
  - Single clock frame_clk; Reset is synchronous and active-high.
  - Reset values: all outputs zero; FSM = IDLE; gap counter = 0; grace counters = 0; LFSR = LFSR_SEED.
- LFSR
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every frame_clk when not in Reset, regardless of FSM state.
- FSM
  - IDLE: go to WAIT when game_active=1; gap counter loads the current gap.
  - WAIT: counter decrements each frame. At 0, go to PICK.
  - PICK: choose the lowest-index slot with visible=0.
    - If one is found, latch its parameters from the current LFSR value and go to LAUNCH.
    - If none is free, reload the gap and return to WAIT; no launch.
  - LAUNCH: for exactly one frame:
    - assert fruit_reset[i];
    - set visible[i]=1;
    - load grace[i]=GRACE;
    - increment launch_count, saturating at 16'hFFFF.
    - Then reload the gap and go to WAIT.
  - game_active=0 in any state: return to IDLE next frame. A LAUNCH already in progress completes its pulse. In-flight fruits keep visible until they retire.
- Parameter derivation (r = LFSR snapshot at PICK)
  - xStart = 192 + r[7:0], range 192..447.
  - increment = 6 + r[10:9], range 6..9.
  - xincrement = r[12:11], range 0..3.
  - negate = (xStart >= 320), so fruits head toward the centre.
  - Per-slot parameter outputs are registered and stay stable from the LAUNCH frame until that slot's next launch.
- Retirement
  - grace[i] decrements to 0 each frame.
  - visible[i] clears the frame after offstage[i]=1 is sampled with grace[i]=0.
  - If retirement and a launch of the same slot fall on the same frame, the launch wins: visible stays 1 and grace reloads.
- fruit_reset never asserts more than one bit in any frame.
- Reset mid-flight: all visible bits clear and no pulse is issued.

Optional Feature:
- Macro: FRUIT_LAUNCHER_DIFFICULTY_RAMP_EN.
- Defined:
  - The current gap starts at LAUNCH_GAP.
  - Every 8th launch (launch_count[2:0] wrapping to 0) reduces the gap by 4, floored at MIN_GAP.
  - Reset restores LAUNCH_GAP.
- Undefined: the gap is fixed at LAUNCH_GAP and MIN_GAP is unused.

Decomposition:
- fruit_pkg holds:
  - launcher_state_t enum {IDLE, WAIT, PICK, LAUNCH};
  - X_BASE=192, INC_BASE=6, X_CENTRE=320;
  - LFSR tap mask.
- One sub-module, lfsr16: enable, synchronous load of seed, 16-bit state out.
- Priority pick is an inline function, not a module.

Test Plan:
- Reset, game_active=1, LAUNCH_GAP=60, all offstage=0 → first fruit_reset[0] pulse 62 frames after Reset release; xStart/increment match the LFSR model for seed 16'hACE1; visible[0]=1.
- Three slots busy, fourth attempt → PICK finds no free slot: no pulse, launch_count unchanged, gap restarts.
- offstage[1]=1 within GRACE frames of its launch → visible[1] stays 1. offstage[1]=1 at grace=0 → visible[1]=0 next frame.
- Slot 0 free and retiring on the same frame it is picked → launch wins: visible[0]=1 and grace reloads to 4.
- game_active dropped during WAIT → FSM reaches IDLE next frame, no further pulses; visible bits still clear on offstage. Reset asserted mid-flight → all outputs 0 next frame.
- Ramp macro defined, 16 launches → gap 60→56→52; forced long run floors at 20. Macro undefined → gap stays 60.
